// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state encodings.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SHR    = 4'd1,
    OP_SHL    = 4'd2,
    OP_XOR    = 4'd3,
    OP_SUB    = 4'd4,
    OP_AND    = 4'd5,
    OP_OR     = 4'd6,
    OP_MUL    = 4'd7,
    OP_SHRN   = 4'd8,
    OP_SHLN   = 4'd9,
    OP_RSV10  = 4'd10,
    OP_RSV11  = 4'd11,
    OP_RSV12  = 4'd12,
    OP_RSV13  = 4'd13,
    OP_RSV14  = 4'd14,
    OP_RSV15  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // True for opcodes that may iterate; a zero-amount shift still finishes in one cycle.
  function automatic logic is_multicycle(alu_op_e op);
    return (op == OP_MUL) || (op == OP_SHRN) || (op == OP_SHLN);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations; iterative and reserved opcodes yield 0.
// Carry output exists only when ALU_CARRY_EN is defined.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  alu_op_e      op_i,
  output logic [W-1:0] res_o
`ifdef ALU_CARRY_EN
  ,
  output logic         carry_o
`endif
);

  always_comb begin
    res_o = '0;
`ifdef ALU_CARRY_EN
    carry_o = 1'b0;
`endif
    case (op_i)
      OP_ADD: begin
`ifdef ALU_CARRY_EN
        {carry_o, res_o} = {1'b0, a_i} + {1'b0, b_i};
`else
        res_o = a_i + b_i;
`endif
      end
      OP_SUB: begin
`ifdef ALU_CARRY_EN
        // Carry set means no borrow.
        {carry_o, res_o} = {1'b0, a_i} + {1'b0, ~b_i} + (W+1)'(1);
`else
        res_o = a_i - b_i;
`endif
      end
      OP_SHR: begin
        res_o = a_i >> 1;
`ifdef ALU_CARRY_EN
        carry_o = a_i[0];
`endif
      end
      OP_SHL: begin
        res_o = a_i << 1;
`ifdef ALU_CARRY_EN
        carry_o = a_i[W-1];
`endif
      end
      OP_XOR:  res_o = a_i ^ b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready handshake, iterative MUL/SHRN/SHLN, registered result and flags.
// Defining ALU_CARRY_EN adds a registered Carry output.
module alu_mc
  import alu_pkg::*;
#(
  parameter int W   = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [OPW-1:0] OP,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out,
  output logic           Zero,
  output logic           Sign
`ifdef ALU_CARRY_EN
  ,
  output logic           Carry
`endif
);

  localparam int CW = $clog2(W) + 1;

  alu_state_e     state_q, state_d;
  alu_op_e        op_q, op_d, op_in;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   work_q, work_d, work_n;
  logic [2*W-1:0] acc_q, acc_d, acc_n, mcand_q, mcand_d;
  logic [W-1:0]   out_q, out_d, res_n, core_res;
  logic           zero_q, zero_d, sign_q, sign_d, load;
  logic [CW-2:0]  amt;
`ifdef ALU_CARRY_EN
  logic           carry_q, carry_d, carry_n, core_carry;
`endif

  assign op_in = alu_op_e'(OP[3:0]);
  assign amt   = B[CW-2:0];

  alu_comb_core #(.W(W)) u_core (
    .a_i   (A),
    .b_i   (B),
    .op_i  (op_in),
    .res_o (core_res)
`ifdef ALU_CARRY_EN
    ,
    .carry_o (core_carry)
`endif
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    out_d   = out_q;
    zero_d  = zero_q;
    sign_d  = sign_q;
    res_n   = '0;
    load    = 1'b0;
    acc_n   = '0;
    work_n  = '0;
`ifdef ALU_CARRY_EN
    carry_d = carry_q;
    carry_n = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = op_in;
          if (op_in == OP_MUL) begin
            state_d = BUSY;
            cnt_d   = CW'(W);
            acc_d   = '0;
            mcand_d = {{W{1'b0}}, A};
            work_d  = B;
          end else if (is_multicycle(op_in) && (amt != '0)) begin
            state_d = BUSY;
            cnt_d   = {1'b0, amt};
            work_d  = A;
          end else begin
            state_d = DONE;
            load    = 1'b1;
            // Zero-amount shifts pass A through with no carry.
            res_n   = is_multicycle(op_in) ? A : core_res;
`ifdef ALU_CARRY_EN
            carry_n = is_multicycle(op_in) ? 1'b0 : core_carry;
`endif
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          acc_n   = acc_q + (work_q[0] ? mcand_q : '0);
          acc_d   = acc_n;
          mcand_d = mcand_q << 1;
          work_d  = work_q >> 1;
          res_n   = acc_n[W-1:0];
`ifdef ALU_CARRY_EN
          carry_n = |acc_n[2*W-1:W];
`endif
        end else begin
          work_n = (op_q == OP_SHLN) ? (work_q << 1) : (work_q >> 1);
          work_d = work_n;
          res_n  = work_n;
`ifdef ALU_CARRY_EN
          carry_n = (op_q == OP_SHLN) ? work_q[W-1] : work_q[0];
`endif
        end
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          load    = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      out_d  = res_n;
      zero_d = (res_n == '0);
      sign_d = res_n[W-1];
`ifdef ALU_CARRY_EN
      carry_d = carry_n;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      work_q  <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
`ifdef ALU_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
`ifdef ALU_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign Zero      = zero_q;
  assign Sign      = sign_q;
`ifdef ALU_CARRY_EN
  assign Carry     = carry_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results queued at issue, compared when out_valid appears.
module tb_alu_mc;
  localparam int W = 8;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, Zero, Sign;
  logic [W-1:0] A = '0, B = '0, out;
  logic [3:0]   OP = '0;
`ifdef ALU_CARRY_EN
  logic         Carry;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         z, s, c;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  alu_mc #(.W(W), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .OP(OP), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .Zero(Zero), .Sign(Sign)
`ifdef ALU_CARRY_EN
    , .Carry(Carry)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    exp_t e;
    logic [8:0]  s9;
    logic [15:0] p;
    int amt;
    amt   = int'(b[2:0]);
    e.res = 8'h00; e.c = 1'b0; e.lat = 1;
    case (op)
      4'd0: begin s9 = {1'b0, a} + {1'b0, b}; e.res = s9[7:0]; e.c = s9[8]; end
      4'd1: begin e.res = a >> 1; e.c = a[0]; end
      4'd2: begin e.res = a << 1; e.c = a[7]; end
      4'd3: e.res = a ^ b;
      4'd4: begin s9 = {1'b0, a} + {1'b0, ~b} + 9'd1; e.res = s9[7:0]; e.c = s9[8]; end
      4'd5: e.res = a & b;
      4'd6: e.res = a | b;
      4'd7: begin p = {8'h00, a} * {8'h00, b}; e.res = p[7:0]; e.c = |p[15:8]; e.lat = W + 1; end
      4'd8: begin e.res = a >> amt; e.c = (amt != 0) ? a[amt-1] : 1'b0; e.lat = amt + 1; end
      4'd9: begin e.res = a << amt; e.c = (amt != 0) ? a[8-amt] : 1'b0; e.lat = amt + 1; end
      default: e.res = 8'h00;
    endcase
    e.z = (e.res == 8'h00);
    e.s = e.res[7];
    return e;
  endfunction

  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input int hold);
    exp_t g;
    int   lat;
    bit   bad_rdy, bad_hold;
    bad_rdy = 0; bad_hold = 0;
    sb.push_back(model(a, b, op));
    @(negedge clk);
    A = a; B = b; OP = op; in_valid = 1'b1; out_ready = (hold == 0);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) bad_rdy = 1;
      @(posedge clk); #1;
      lat++;
    end
    g = sb.pop_front();
    chk({nm, "_busy_rdy"}, 32'(bad_rdy), 32'd0);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_done_rdy"}, 32'(in_ready), 32'd0);
    chk({nm, "_lat"}, 32'(lat), 32'(g.lat));
    chk({nm, "_out"}, 32'(out), 32'(g.res));
    chk({nm, "_zero"}, 32'(Zero), 32'(g.z));
    chk({nm, "_sign"}, 32'(Sign), 32'(g.s));
`ifdef ALU_CARRY_EN
    chk({nm, "_carry"}, 32'(Carry), 32'(g.c));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out !== g.res || Sign !== g.s || Zero !== g.z) bad_hold = 1;
    end
    if (hold > 0) chk({nm, "_hold"}, 32'(bad_hold), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_idle"}, 32'(in_ready), 32'd1);
    chk({nm, "_vlow"}, 32'(out_valid), 32'd0);
    chk({nm, "_kept"}, 32'(out), 32'(g.res));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_zero", 32'(Zero), 32'd0);
    chk("rst_sign", 32'(Sign), 32'd0);
    rst_n = 1'b1;

    run_op("add_wrap", 8'hFF, 8'h01, 4'd0, 0);
    run_op("mul",      8'd13, 8'd11, 4'd7, 0);
    run_op("shrn3",    8'hF0, 8'd3,  4'd8, 0);
    run_op("shrn0",    8'hF0, 8'd0,  4'd8, 0);
    run_op("shln7",    8'h81, 8'd7,  4'd9, 0);
    run_op("rsv",      8'hAA, 8'h55, 4'hF, 0);
    run_op("sub_bp",   8'h05, 8'h07, 4'd4, 5);

    // Reset three cycles into a MUL: immediate abort, no late result.
    @(negedge clk);
    A = 8'd13; B = 8'd11; OP = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out", 32'(out), 32'd0);
    chk("abort_sign", 32'(Sign), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);

    for (int i = 0; i < 24; i++) begin
      run_op("rand", 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised ALU for the CPU datapath; successor to the 2-bit, 4-op combinational ALU.
- Single-cycle ops plus iterative ops: multiply, and shift-by-amount.
- Uses a valid/ready handshake on both the operand side and the result side.
- Result and flags are registered; sits between register-file read and writeback.

Parameters:
- W, 8, datapath width in bits (W >= 4, power of two).
- OPW, 4, opcode width.
- CW, $clog2(W)+1, iteration counter width (derived, localparam).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept operation
- A  in  W  operand A
- B  in  W  operand B / shift amount (B[CW-2:0])
- OP  in  OPW  opcode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  W  registered result
- Zero  out  1  out == 0
- Sign  out  1  out[W-1]

Behaviour:
- One clock (clk); reset rst_n asynchronous, active-low.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, out = 0, Zero = 0, Sign = 0.
  - All internal registers = 0.
- Opcodes:
  - 0 ADD: A+B mod 2^W
  - 1 SHR: logical right by 1
  - 2 SHL: left by 1
  - 3 XOR
  - 4 SUB: A-B mod 2^W
  - 5 AND
  - 6 OR
  - 7 MUL: low W bits of A*B
  - 8 SHRN: logical right by B[CW-2:0]
  - 9 SHLN: left by B[CW-2:0]
  - 10-15 reserved: result 0, single-cycle
- FSM states IDLE, BUSY, DONE:
  - in_ready = (state == IDLE). Accept occurs on in_valid && in_ready; A, B and OP are captured.
  - IDLE, single-cycle op accepted: result registered, go to DONE. out_valid is high the cycle after accept (latency 1).
  - IDLE, MUL accepted: go to BUSY, counter = W. Shift-add, one multiplier bit per cycle. When counter reaches 0, go to DONE. out_valid is high exactly W+1 cycles after accept.
  - IDLE, SHRN/SHLN accepted:
    - If the amount is 0: go to DONE, result = A (latency 1).
    - Otherwise: go to BUSY with counter = amount, shifting 1 bit per cycle. out_valid is high amount+1 cycles after accept.
  - DONE: out_valid = 1. out, Zero and Sign stay stable until out_ready is sampled high, then go to IDLE.
  - Same-cycle re-accept in DONE is not allowed; minimum issue interval is 2 cycles.
- Zero and Sign are computed from the result being registered and update together with out. They keep their last values after handoff.
- in_valid while BUSY/DONE is ignored (in_ready = 0); the upstream must hold.
- Reset asserted mid-BUSY: immediate abort, all reset values, and no out_valid pulse afterwards.
- Arithmetic:
  - All ops wrap modulo 2^W; no saturation.
  - MUL accumulator is 2W bits internally; only the low W bits are output.

Optional Feature:
- Macro ALU_CARRY_EN.
- Defined:
  - Adds output port Carry (1 bit, reset 0), registered with out.
  - ADD: bit W of A+B.
  - SUB: bit W of A+~B+1 (1 = no borrow).
  - SHR/SHL: the bit shifted out.
  - SHRN/SHLN: the last bit shifted out; 0 if the amount is 0.
  - MUL: 1 if the upper W product bits are nonzero.
  - Logic/reserved ops: 0.
- Undefined: no Carry port and no carry logic; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - typedef enum alu_op_e for the opcodes above, including the reserved range.
  - typedef enum alu_state_e {IDLE, BUSY, DONE}.
  - Function is_multicycle(op).
- Sub-module alu_comb_core: purely combinational single-cycle ops (ADD, SUB, SHR, SHL, XOR, AND, OR, reserved), with optional carry.
- alu_mc owns the FSM, handshake, MUL and SHRN/SHLN iteration, and the output registers.

Test Plan:
- ADD, A=8'hFF, B=8'h01, out_ready=1:
  - out_valid 1 cycle after accept, out=8'h00, Zero=1, Sign=0.
  - Carry=1 with ALU_CARRY_EN.
- MUL, A=8'd13, B=8'd11:
  - out_valid exactly 9 cycles after accept, out=8'h8F, Sign=1, Zero=0.
  - in_ready=0 throughout BUSY.
- SHRN, A=8'hF0:
  - B=3: out=8'h1E, out_valid 4 cycles after accept.
  - B=0: out=8'hF0, latency 1.
- Backpressure: SUB A=8'h05, B=8'h07 with out_ready low for 5 cycles:
  - out=8'hFE, Sign=1, held stable.
  - out_valid stays 1 and in_ready stays 0 until out_ready rises; IDLE the next cycle.
- Reset mid-operation: rst_n pulled low 3 cycles into a MUL:
  - out=0, out_valid=0, in_ready=1 immediately.
  - No out_valid pulse after release.
- Reserved OP=4'hF, A=8'hAA: out=8'h00, Zero=1, latency 1.
